// File: rtl/barrel_shifter_sync.sv
// Registered N-bit barrel shifter: rotate-left, logical left/right and arithmetic
// right shift through a log2(N)-stage mux network, result held in an output register.
module barrel_shifter_sync #(
    parameter int N    = 8,
    parameter int LOGN = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in,
    input  logic [LOGN-1:0] sh_sel,
    input  logic [1:0]      mode,
    input  logic            in_valid,
    output logic [N-1:0]    out,
    output logic            out_valid
);

    typedef enum logic [1:0] {
        MODE_ROL = 2'b00,
        MODE_SLL = 2'b01,
        MODE_SRL = 2'b10,
        MODE_SRA = 2'b11
    } mode_e;

    mode_e                  modeSel;
    logic [LOGN:0][N-1:0]   stageW;
    logic [N-1:0]           out_d;
    logic [N-1:0]           out_q;
    logic                   out_valid_d;
    logic                   out_valid_q;

    assign modeSel = mode_e'(mode);

    // Stage i moves the word by 2^i when sh_sel[i] is set; SRA keeps the sign
    // because every stage refills from the current MSB, which never changes.
    always_comb begin
        stageW[0] = in;
        for (int i = 0; i < LOGN; i++) begin
            stageW[i+1] = stageW[i];
            if (sh_sel[i]) begin
                case (modeSel)
                    MODE_ROL: stageW[i+1] = (stageW[i] << (1 << i)) | (stageW[i] >> (N - (1 << i)));
                    MODE_SLL: stageW[i+1] = stageW[i] << (1 << i);
                    MODE_SRL: stageW[i+1] = stageW[i] >> (1 << i);
                    MODE_SRA: stageW[i+1] = $signed(stageW[i]) >>> (1 << i);
                    default:  stageW[i+1] = stageW[i];
                endcase
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d = stageW[LOGN];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_barrel_shifter_sync.sv
// Self-checking bench for barrel_shifter_sync: directed vector table, reset and
// hold sequences, then a randomized sweep against an arithmetic reference model.
module tb_barrel_shifter_sync;

    localparam int N    = 8;
    localparam int LOGN = 3;

    typedef struct {
        logic [1:0]      mode;
        logic [N-1:0]    din;
        logic [LOGN-1:0] sh;
        logic [N-1:0]    expOut;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in;
    logic [LOGN-1:0] sh_sel;
    logic [1:0]      mode;
    logic            in_valid;
    logic [N-1:0]    out;
    logic            out_valid;

    int passCount  = 0;
    int checkCount = 0;

    barrel_shifter_sync #(.N(N), .LOGN(LOGN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .sh_sel    (sh_sel),
        .mode      (mode),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference computed with plain integer arithmetic rather than bit shifting networks.
    function automatic logic [N-1:0] refModel(input logic [1:0] m, input logic [N-1:0] d, input int s);
        int unsigned u;
        int          v;
        int          p;
        logic [2*N-1:0] dbl;
        u = int'(d);
        p = 1;
        for (int k = 0; k < s; k++) p = p * 2;
        case (m)
            2'b00: begin
                dbl = {d, d};
                dbl = dbl >> (N - s);
                return dbl[N-1:0];
            end
            2'b01: return N'((u * p) % (1 << N));
            2'b10: return N'(u / p);
            default: begin
                v = d[N-1] ? int'(u) - (1 << N) : int'(u);
                v = (v - (((v % p) + p) % p)) / p;
                return N'(v);
            end
        endcase
    endfunction

    task automatic applyStimulus(input logic rstN, input logic valid, input logic [1:0] m,
                                 input logic [N-1:0] d, input logic [LOGN-1:0] s);
        @(negedge clk);
        rst_n    = rstN;
        in_valid = valid;
        mode     = m;
        in       = d;
        sh_sel   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] expOut, input logic expValid);
        checkCount++;
        if (out === expOut && out_valid === expValid) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: out=%b out_valid=%b, expected out=%b out_valid=%b",
                     name, out, out_valid, expOut, expValid);
        end
    endtask

    initial begin
        vec_t vecs[$];
        logic [N-1:0] expOut;
        logic [N-1:0] d;
        logic [1:0]   m;
        logic         v;

        vecs.push_back('{2'b00, 8'b10011101, 3'd7, 8'b11001110});
        vecs.push_back('{2'b00, 8'b11100101, 3'd1, 8'b11001011});
        vecs.push_back('{2'b00, 8'b01011011, 3'd3, 8'b11011010});
        vecs.push_back('{2'b01, 8'b10011101, 3'd7, 8'b10000000});
        vecs.push_back('{2'b10, 8'b11100101, 3'd1, 8'b01110010});
        vecs.push_back('{2'b11, 8'b11100101, 3'd1, 8'b11110010});
        vecs.push_back('{2'b11, 8'b10011101, 3'd7, 8'b11111111});
        vecs.push_back('{2'b11, 8'b01011011, 3'd3, 8'b00001011});
        vecs.push_back('{2'b00, 8'b10100101, 3'd0, 8'b10100101});
        vecs.push_back('{2'b01, 8'b10100101, 3'd0, 8'b10100101});
        vecs.push_back('{2'b10, 8'b10100101, 3'd0, 8'b10100101});
        vecs.push_back('{2'b11, 8'b10100101, 3'd0, 8'b10100101});
        vecs.push_back('{2'b10, 8'b10011101, 3'd7, 8'b00000001});

        rst_n = 1'b0; in_valid = 1'b1; mode = 2'b00; in = 8'hFF; sh_sel = 3'd1;

        applyStimulus(1'b0, 1'b1, 2'b00, 8'hFF, 3'd1);
        checkOutput("reset_cycle1", 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b01, 8'hA5, 3'd2);
        checkOutput("reset_cycle2", 8'h00, 1'b0);

        applyStimulus(1'b1, 1'b1, 2'b00, 8'b00000011, 3'd2);
        checkOutput("first_after_reset", 8'b00001100, 1'b1);

        // Back-to-back directed vectors, one per cycle.
        foreach (vecs[i]) begin
            applyStimulus(1'b1, 1'b1, vecs[i].mode, vecs[i].din, vecs[i].sh);
            checkOutput($sformatf("vec%0d", i), vecs[i].expOut, 1'b1);
        end

        expOut = vecs[vecs.size()-1].expOut;
        applyStimulus(1'b1, 1'b0, 2'b11, 8'b01010101, 3'd5);
        checkOutput("hold_idle1", expOut, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b01, 8'b11110000, 3'd2);
        checkOutput("hold_idle2", expOut, 1'b0);

        applyStimulus(1'b1, 1'b1, 2'b01, 8'b00001111, 3'd4);
        checkOutput("pre_midreset", 8'b11110000, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'b00, 8'b10011101, 3'd7);
        checkOutput("midstream_reset", 8'h00, 1'b0);

        // Random sweep: every mode and shift amount, with random idle cycles.
        expOut = 8'h00;
        for (int rep = 0; rep < 4; rep++) begin
            for (int mi = 0; mi < 4; mi++) begin
                for (int s = 0; s < N; s++) begin
                    m = 2'(mi);
                    d = N'($urandom);
                    v = ($urandom_range(0, 3) != 0);
                    applyStimulus(1'b1, v, m, d, LOGN'(s));
                    if (v) expOut = refModel(m, d, s);
                    checkOutput($sformatf("rand_m%0d_s%0d_r%0d", mi, s, rep), expOut, v);
                end
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
